// File: rtl/genomatic_pkg.sv
// rtl/genomatic_pkg.sv - shared types, pattern table and sizes for the genomatic scan datapath
package genomatic_pkg;

  typedef enum logic [1:0] {A = 2'b00, C = 2'b01, G = 2'b10, T = 2'b11} base_t;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam int PAT_LEN = 4;

  // First base of each pattern sits in [7:6].
  localparam logic [7:0] PATTERNS [0:7] = '{
    8'h00,  // AAAA
    8'h1B,  // ACGT
    8'hFF,  // TTTT
    8'h8D,  // GATC
    8'h5A,  // CCGG
    8'hCC,  // TATA
    8'hAA,  // GGGG
    8'h4B   // CAGT
  };

endpackage

// File: rtl/base_window.sv
// rtl/base_window.sv - 4-base sliding window with fill tracking and pattern match strobe
module base_window
  import genomatic_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       cap_i,
  input  logic [1:0] base_i,
  input  logic [7:0] pat_i,
  output logic       match_o
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);

  logic [5:0]        win_q;
  logic [FILL_W-1:0] fill_q;
  logic [7:0]        win_d;

  assign win_d = {win_q, base_i};

  // Only the three most recent bases are stored; the incoming base completes the window.
  assign match_o = cap_i && (fill_q >= FILL_W'(PAT_LEN - 1)) && (win_d == pat_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      if (cap_i) begin
        win_q <= win_d[5:0];
        if (fill_q != FILL_W'(PAT_LEN)) fill_q <= fill_q + 1'b1;
      end
      if (clr_i) fill_q <= '0;
    end
  end

endmodule

// File: rtl/genome_scan_ctrl.sv
// rtl/genome_scan_ctrl.sv - ROM walk sequencer counting overlapping 4-base pattern hits
module genome_scan_ctrl
  import genomatic_pkg::*;
#(
  parameter int SEQ_LEN = 64,
  parameter int ADDR_W  = 6,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_btn,
  input  logic              start,
  input  logic [2:0]        sw,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [1:0]        rom_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  match_count,
  output logic [3:0]        led
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SEQ_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rom_en_q;
  logic              busy_q;
  logic              done_q;
  logic              cap_q;
  logic [7:0]        pat_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              accept;
  logic              match;

  assign accept = (state_q == IDLE) && start;
  assign cnt_d  = (match && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;

  base_window u_window (
    .clk     (clk),
    .rst     (rst_btn),
    .clr_i   (accept),
    .cap_i   (cap_q),
    .base_i  (rom_data),
    .pat_i   (pat_q),
    .match_o (match)
  );

  // cap_q marks the cycle in which rom_data answers the previous cycle's read.
  always_ff @(posedge clk or posedge rst_btn) begin
    if (rst_btn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rom_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cap_q    <= 1'b0;
      pat_q    <= PATTERNS[0];
      cnt_q    <= '0;
    end else begin
      cap_q <= rom_en_q;
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            pat_q    <= PATTERNS[sw];
            cnt_q    <= '0;
            addr_q   <= '0;
            rom_en_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= SCAN;
          end
        end
        SCAN: begin
          if (addr_q == LAST_ADDR) begin
            rom_en_q <= 1'b0;
            state_q  <= DRAIN;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        DRAIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          addr_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_addr    = addr_q;
  assign rom_en      = rom_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign match_count = cnt_q;
  assign led         = {busy_q, (cnt_q > CNT_W'(7)) ? 3'd7 : cnt_q[2:0]};

endmodule

// File: tb/tb_genome_scan_ctrl.sv
// tb/tb_genome_scan_ctrl.sv - directed table-driven bench for genome_scan_ctrl
module tb_genome_scan_ctrl;

  localparam int SEQ_LEN = 64;
  localparam int ADDR_W  = 6;

  logic              clk;
  logic              rst_btn;
  logic              start;
  logic [2:0]        sw;
  logic [ADDR_W-1:0] rom_addr, rom_addr2;
  logic              rom_en, rom_en2;
  logic [1:0]        rom_data, rom_data2;
  logic              busy, busy2;
  logic              done, done2;
  logic [7:0]        match_count;
  logic [3:0]        match_count2;
  logic [3:0]        led, led2;

  logic [1:0] mem [0:SEQ_LEN-1];

  int checks = 0;
  int errors = 0;

  genome_scan_ctrl #(.SEQ_LEN(SEQ_LEN), .ADDR_W(ADDR_W), .CNT_W(8)) dut (
    .clk(clk), .rst_btn(rst_btn), .start(start), .sw(sw),
    .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
    .busy(busy), .done(done), .match_count(match_count), .led(led)
  );

  genome_scan_ctrl #(.SEQ_LEN(SEQ_LEN), .ADDR_W(ADDR_W), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_btn(rst_btn), .start(start), .sw(sw),
    .rom_addr(rom_addr2), .rom_en(rom_en2), .rom_data(rom_data2),
    .busy(busy2), .done(done2), .match_count(match_count2), .led(led2)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  always @(posedge clk) begin
    if (rom_en)  rom_data  <= mem[rom_addr];
    if (rom_en2) rom_data2 <= mem[rom_addr2];
  end

  typedef struct {
    int         mode;
    logic [2:0] sel;
    int         exp_cnt;
    logic [3:0] exp_led;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_rom(input int mode);
    for (int i = 0; i < SEQ_LEN; i++) begin
      case (mode)
        0: mem[i] = 2'b00;
        1: mem[i] = 2'(i % 4);
        2: mem[i] = 2'b11;
        3: mem[i] = (i % 2 == 0) ? 2'b11 : 2'b00;
        default: mem[i] = 2'b00;
      endcase
    end
    if (mode == 4) begin
      mem[10] = 2'b01; mem[11] = 2'b00; mem[12] = 2'b10; mem[13] = 2'b11;
    end
  endtask

  task automatic run_scan(input string tag, input int exp_cnt, input logic [3:0] exp_led,
                          input bit disturb);
    int busy_n, done_at, done_n, en_n, addr_err;
    busy_n = 0; done_at = -1; done_n = 0; en_n = 0; addr_err = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= SEQ_LEN + 4; c++) begin
      if (busy) busy_n++;
      if (done) begin done_n++; done_at = c; end
      if (rom_en) begin
        if (rom_addr != en_n[ADDR_W-1:0]) addr_err++;
        en_n++;
      end
      if (disturb) begin
        if (c == 20) sw = sw ^ 3'b011;
        if (c == 30 || c == SEQ_LEN + 2) start = 1'b1;
        if (c == 31 || c == SEQ_LEN + 3) start = 1'b0;
      end
      @(negedge clk);
    end
    chk({tag, ".busy_cycles"}, busy_n, SEQ_LEN + 1);
    chk({tag, ".done_cycle"}, done_at, SEQ_LEN + 2);
    chk({tag, ".done_pulses"}, done_n, 1);
    chk({tag, ".rom_reads"}, en_n, SEQ_LEN);
    chk({tag, ".addr_seq_errs"}, addr_err, 0);
    chk({tag, ".match_count"}, match_count, exp_cnt);
    chk({tag, ".led"}, led, exp_led);
    chk({tag, ".sat_count"}, match_count2, (exp_cnt > 15) ? 15 : exp_cnt);
    chk({tag, ".sat_led"}, led2, exp_led);
  endtask

  initial begin
    int n, d1, d2, m1, m2, gap;

    vecs[0] = '{0, 3'd0, 61, 4'b0111};
    vecs[1] = '{1, 3'd1, 16, 4'b0111};
    vecs[2] = '{1, 3'd3, 0,  4'b0000};
    vecs[3] = '{2, 3'd2, 61, 4'b0111};
    vecs[4] = '{3, 3'd5, 31, 4'b0111};
    vecs[5] = '{4, 3'd7, 1,  4'b0001};
    vecs[6] = '{1, 3'd0, 0,  4'b0000};

    rst_btn = 1'b1; start = 1'b0; sw = 3'd0;
    fill_rom(0);
    @(negedge clk); @(negedge clk);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.rom_en", rom_en, 0);
    chk("reset.rom_addr", rom_addr, 0);
    chk("reset.match_count", match_count, 0);
    chk("reset.led", led, 0);
    rst_btn = 1'b0;

    for (int v = 0; v < 7; v++) begin
      fill_rom(vecs[v].mode);
      sw = vecs[v].sel;
      run_scan($sformatf("vec%0d", v), vecs[v].exp_cnt, vecs[v].exp_led, 1'b0);
    end

    fill_rom(1); sw = 3'd1;
    run_scan("disturb", 16, 4'b0111, 1'b1);

    sw = 3'd1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (rom_addr != 6'd20 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst.reach_addr20", n < 100, 1);
    chk("rst.count_before", match_count, 4);
    #10 rst_btn = 1'b1;
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.match_count", match_count, 0);
    chk("rst.led", led, 0);
    chk("rst.rom_en", rom_en, 0);
    chk("rst.rom_addr", rom_addr, 0);
    #5 rst_btn = 1'b0;
    run_scan("after_rst", 16, 4'b0111, 1'b0);

    d1 = -1; d2 = -1; m1 = -1; m2 = -1; gap = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 200 && d2 < 0; c++) begin
      if (done) begin
        if (d1 < 0) begin
          d1 = c; m1 = match_count;
        end else begin
          d2 = c; m2 = match_count; start = 1'b0;
        end
      end else if (d1 > 0 && !busy) begin
        gap++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("held.first_done", d1, SEQ_LEN + 2);
    chk("held.second_done", d2, 2 * SEQ_LEN + 5);
    chk("held.idle_gap", gap, 1);
    chk("held.count1", m1, 16);
    chk("held.count2", m2, 16);
    repeat (3) @(negedge clk);
    chk("held.final_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/genome_scan_ctrl.md
Name: genome_scan_ctrl

Overview:
Sequencer for the genomatic datapath. On a start request it walks the nucleotide ROM address by address and slides a 4-base window over the returned bases. It counts every occurrence, overlaps included, of the 4-base pattern chosen by the board switches. It exports busy/done status and drives the 4 board LEDs with status and result.

Parameters:
SEQ_LEN, 64, number of bases in ROM (must be >= PAT_LEN)
ADDR_W, 6, ROM address width; 2**ADDR_W >= SEQ_LEN
CNT_W, 8, match counter width; counter saturates at 2**CNT_W-1

Ports:
clk  in  1  system clock (10 MHz board clock)
rst_btn  in  1  asynchronous, active-high reset
start  in  1  scan request; sampled only in IDLE, level or pulse
sw  in  3  pattern select index into package pattern table; latched at accepted start
rom_addr  out  ADDR_W  ROM read address
rom_en  out  1  ROM read enable
rom_data  in  2  base returned by ROM; valid the cycle after rom_addr/rom_en presented
busy  out  1  high from accepted start through last base captured
done  out  1  one-cycle pulse when result final
match_count  out  CNT_W  number of matches from last completed or ongoing scan
led  out  4  led[3]=busy, led[2:0]=min(match_count,7)

Behaviour:
- Reset is asynchronous, active-high, and applies in any state, including mid-scan. On reset: state=IDLE, rom_addr=0, rom_en=0, busy=0, done=0, match_count=0, led=0, window=0, base counter=0, latched pattern=PATTERNS[0].
- Base encoding: A=00, C=01, G=10, T=11. A pattern is 8 bits with the first base in [7:6].
- States:
  - IDLE: start=1 latches pat<=PATTERNS[sw], clears match_count and the window fill count, and goes to SCAN.
  - SCAN: rom_en=1, busy=1. rom_addr starts at 0 and increments by 1 each cycle. At address SEQ_LEN-1 the next state is DRAIN.
  - DRAIN: rom_en=0, busy=1. This state captures the final base, then goes to DONE.
  - DONE: busy=0, done=1 for one cycle, then goes to IDLE.
- Capture happens every cycle whose previous cycle had rom_en=1:
  - window <= {window[5:0], rom_data}.
  - fill <= sat(fill+1, 4).
  - If fill>=3 and {window[5:0],rom_data}==pat, then match_count <= sat(match_count+1).
- Latency: accepted start at edge E0. rom_addr=0 is presented at E0+. busy is high for SEQ_LEN+1 cycles. done is high in cycle SEQ_LEN+2 after E0. match_count is final when done is high.
- match_count holds after DONE until the next accepted start or reset.
- start is ignored while in SCAN, DRAIN or DONE; it is not queued. start held high continuously re-triggers from IDLE, with one IDLE cycle between scans.
- sw changes during a scan have no effect.
- Saturation: match_count never wraps; it sticks at 2**CNT_W-1.
- rom_addr does not increment past SEQ_LEN-1. It returns to 0 on DONE->IDLE.

Decomposition:
- Package genomatic_pkg holds:
  - base_t enum {A,C,G,T} (2-bit)
  - state_t enum {IDLE,SCAN,DRAIN,DONE}
  - PAT_LEN=4
  - PATTERNS[0:7] (8-bit each): 0 AAAA, 1 ACGT, 2 TTTT, 3 GATC, 4 CCGG, 5 TATA, 6 GGGG, 7 CAGT
- Natural sub-module: base_window. It contains the 4-base shift register, the fill counter, the comparator against pat, and a match strobe output. The FSM, address counter and saturating counter stay in genome_scan_ctrl.
- The ROM is external; the bench uses a behavioural 1-cycle-latency model.

Test Plan:
- ROM all A, sw=0, start pulse -> busy high 65 cycles, done pulse at cycle 66, match_count=61, led=4'b0111 after done.
- ROM repeating ACGT, sw=1 -> match_count=16. Rerun with sw=3 (GATC) -> match_count=0, cleared from 16 at start.
- CNT_W=4, ROM all A, sw=0 -> match_count saturates at 15, no wrap.
- start pulsed again mid-SCAN and during DONE -> ignored, rom_addr sequence 0..63 uninterrupted, single done pulse. sw changed mid-scan -> result matches latched pattern.
- rst_btn asserted asynchronously at rom_addr=20 -> same-instant busy=0, match_count=0, led=0, state IDLE. A following start gives full correct result.
- start held high -> back-to-back scans separated by exactly one IDLE cycle, identical match_count each run.
